mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/rr_arb2.sv | 16 +
 rtl/mem_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM encoding,
// bus widths and the default read data returned on a timeout.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: a single requester always wins; on contention
// the master that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_m1_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_m1_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates two wait-request style masters onto one slave port, with a
// registered owner, a mandatory idle cycle between transfers and a timeout.
//
// Handshake: a master holds read/write (and its address/data) until it sees
// waitrequest low in a cycle where its strobe is high; that cycle is the
// transfer. The slave side uses the same rule with s_waitrequest.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int                TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_write,
  input  logic              m0_read,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_write,
  input  logic              m1_read,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_write,
  output logic              s_read,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest,
  output logic [1:0]        grant,
  output logic              timeout_err,
  output state_e            dbg_state_o
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_m1_q, last_m1_d;
  logic [31:0] cnt_q, cnt_d;

  logic [1:0]  rr_gnt;
  logic        own_rd, own_wr, own_req, to_hit;

  rr_arb2 u_rr (
    .req_i    ({m1_read | m1_write, m0_read | m0_write}),
    .last_m1_i(last_m1_q),
    .gnt_o    (rr_gnt)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      last_m1_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    own_rd = 1'b0;
    own_wr = 1'b0;
    case (state_q)
      ST_OWN0: begin own_rd = m0_read; own_wr = m0_write; end
      ST_OWN1: begin own_rd = m1_read; own_wr = m1_write; end
      default: ;
    endcase
    own_req = own_rd | own_wr;
    // The counter holds waits already seen; this cycle's wait makes it TIMEOUT.
    to_hit  = (TIMEOUT > 0) && own_req && s_waitrequest && (cnt_q == TO_LAST);
  end

  always_comb begin
    state_d   = state_q;
    last_m1_d = last_m1_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rr_gnt[0])      state_d = ST_OWN0;
        else if (rr_gnt[1]) state_d = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_req || !s_waitrequest || to_hit) begin
          state_d   = ST_IDLE;
          last_m1_d = (state_q == ST_OWN1);
        end else if (cnt_q != 32'hFFFF_FFFF) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_address      = '0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_readdata    = '0;
    m1_readdata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    s_write        = own_wr & ~to_hit;
    s_read         = own_rd & ~own_wr & ~to_hit;
    timeout_err    = to_hit;
    if (state_q == ST_OWN0) begin
      s_address      = m0_address;
      s_writedata    = m0_writedata;
      s_byteenable   = m0_byteenable;
      m0_readdata    = to_hit ? ERR_DATA : s_readdata;
      m0_waitrequest = to_hit ? 1'b0 : s_waitrequest;
    end else if (state_q == ST_OWN1) begin
      s_address      = m1_address;
      s_writedata    = m1_writedata;
      s_byteenable   = m1_byteenable;
      m1_readdata    = to_hit ? ERR_DATA : s_readdata;
      m1_waitrequest = to_hit ? 1'b0 : s_waitrequest;
    end
  end

  assign grant       = {state_q == ST_OWN1, state_q == ST_OWN0};
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single read, alternating writes, slave
// wait states, timeout and reset mid-transfer, with hand-computed expectations.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_write, m0_read, m1_write, m1_read;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_write, s_read, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic        timeout_err;
  state_e      dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_address(m0_address), .m0_write(m0_write), .m0_read(m0_read),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_write(m1_write), .m1_read(m1_read),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_write(s_write), .s_read(s_read),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant), .timeout_err(timeout_err), .dbg_state_o(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then let outputs settle before anyone drives or samples.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_write = 0; m0_read = 0; m1_write = 0; m1_read = 0;
    m0_byteenable = '0; m1_byteenable = '0;
    s_readdata = '0; s_waitrequest = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 0;
    tick(); tick();
    resetn = 1;
  endtask

  initial begin
    logic [1:0] exp_g [6];
    exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

    // Reset values
    do_reset();
    settle();
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("rst_s_rd_wr", {30'd0, s_read, s_write}, 32'h0);
    check_eq("rst_waits", {30'd0, m1_waitrequest, m0_waitrequest}, 32'h3);
    check_eq("rst_m0_rdata", m0_readdata, 32'h0);
    check_eq("rst_terr", 32'(timeout_err), 32'h0);

    // Single m0 read at 0x100, no slave wait
    m0_read = 1; m0_address = 32'h100; m0_byteenable = 4'hF;
    s_readdata = 32'h1234_5678; s_waitrequest = 0;
    settle();
    check_eq("rd_n_s_read", 32'(s_read), 32'h0);
    tick();
    check_eq("rd_n1_grant", 32'(grant), 32'h1);
    check_eq("rd_n1_s_read", 32'(s_read), 32'h1);
    check_eq("rd_n1_addr", s_address, 32'h100);
    check_eq("rd_n1_be", 32'(s_byteenable), 32'hF);
    check_eq("rd_n1_rdata", m0_readdata, 32'h1234_5678);
    check_eq("rd_n1_m0_wait", 32'(m0_waitrequest), 32'h0);
    check_eq("rd_n1_m1_wait", 32'(m1_waitrequest), 32'h1);
    check_eq("rd_n1_m1_rdata", m1_readdata, 32'h0);
    m0_read = 0;
    tick();
    check_eq("rd_n2_grant", 32'(grant), 32'h0);
    check_eq("rd_n2_s_read", 32'(s_read), 32'h0);

    // Both masters write continuously; m0 also holds read high
    do_reset();
    m0_write = 1; m0_read = 1; m0_writedata = 32'hAAAA_0000;
    m1_write = 1; m1_writedata = 32'hBBBB_1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("alt_grant_%0d", i), 32'(grant), 32'(exp_g[i]));
      if (exp_g[i] == 2'b01) begin
        check_eq($sformatf("alt_wdata_%0d", i), s_writedata, 32'hAAAA_0000);
        check_eq($sformatf("alt_rd_forced_%0d", i), {30'd0, s_read, s_write}, 32'h1);
      end else if (exp_g[i] == 2'b10) begin
        check_eq($sformatf("alt_wdata_%0d", i), s_writedata, 32'hBBBB_1111);
        check_eq($sformatf("alt_m0_wait_%0d", i), 32'(m0_waitrequest), 32'h1);
      end else begin
        check_eq($sformatf("alt_idle_wr_%0d", i), 32'(s_write), 32'h0);
      end
    end

    // m1 read with 5 slave wait cycles while m0 queues up
    do_reset();
    m1_read = 1; m1_address = 32'h200; s_waitrequest = 1; s_readdata = 32'h5555_AAAA;
    tick();
    m0_read = 1; m0_address = 32'h300;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_eq($sformatf("w5_grant_%0d", i), 32'(grant), 32'h2);
      check_eq($sformatf("w5_waits_%0d", i), {30'd0, m1_waitrequest, m0_waitrequest}, 32'h3);
      check_eq($sformatf("w5_terr_%0d", i), 32'(timeout_err), 32'h0);
      tick();
    end
    s_waitrequest = 0;
    settle();
    check_eq("w5_done_wait", 32'(m1_waitrequest), 32'h0);
    check_eq("w5_done_rdata", m1_readdata, 32'h5555_AAAA);
    check_eq("w5_done_m0_wait", 32'(m0_waitrequest), 32'h1);
    m1_read = 0;
    tick();
    check_eq("w5_idle_grant", 32'(grant), 32'h0);
    tick();
    check_eq("w5_m0_grant", 32'(grant), 32'h1);
    check_eq("w5_m0_addr", s_address, 32'h300);
    check_eq("w5_m0_wait", 32'(m0_waitrequest), 32'h0);
    m0_read = 0;
    tick();

    // Timeout after 8 wait cycles, then m1 is served
    do_reset();
    m0_read = 1; m1_read = 1; s_waitrequest = 1; s_readdata = 32'hCAFE_0001;
    tick();
    for (int i = 1; i < 8; i++) begin
      settle();
      check_eq($sformatf("to_wait_terr_%0d", i), 32'(timeout_err), 32'h0);
      check_eq($sformatf("to_wait_sread_%0d", i), 32'(s_read), 32'h1);
      tick();
    end
    settle();
    check_eq("to_terr", 32'(timeout_err), 32'h1);
    check_eq("to_rdata", m0_readdata, 32'hDEAD_BEEF);
    check_eq("to_sread", 32'(s_read), 32'h0);
    check_eq("to_m0_wait", 32'(m0_waitrequest), 32'h0);
    check_eq("to_grant", 32'(grant), 32'h1);
    m0_read = 0;
    tick();
    check_eq("to_idle_grant", 32'(grant), 32'h0);
    check_eq("to_idle_terr", 32'(timeout_err), 32'h0);
    tick();
    check_eq("to_next_grant", 32'(grant), 32'h2);
    s_waitrequest = 0;
    settle();
    check_eq("to_next_rdata", m1_readdata, 32'hCAFE_0001);
    m1_read = 0;
    tick();

    // Reset on the second wait cycle of a write
    do_reset();
    m0_write = 1; m0_writedata = 32'h0BAD_F00D; s_waitrequest = 1;
    tick();
    check_eq("rr_wr_c1", 32'(s_write), 32'h1);
    tick();
    resetn = 0;
    tick();
    check_eq("rr_s_write", 32'(s_write), 32'h0);
    check_eq("rr_grant", 32'(grant), 32'h0);
    check_eq("rr_terr", 32'(timeout_err), 32'h0);
    check_eq("rr_m0_wait", 32'(m0_waitrequest), 32'h1);
    resetn = 1; m0_write = 0;
    tick();
    check_eq("rr_after_grant", 32'(grant), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
